// File: rtl/count_seq_checker.sv
// Observer for the 4-bit up/down ring counter: classifies each sampled step, tracks direction lock and faults.
// Pulses, dir, locked, prev_q and counters update on the edge that accepts the sample (1-cycle latency).
// No backpressure: accepts a sample every cycle sample_en is high.
module count_seq_checker #(
  parameter int LOCK_N = 3,
  parameter int CNT_W  = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             sample_en,
  input  logic [3:0]       q_in,
  output logic             step_up,
  output logic             step_dn,
  output logic             hold_det,
  output logic             jump,
  output logic             dir,
  output logic             locked,
  output logic             fault,
  output logic [3:0]       prev_q,
  output logic [CNT_W-1:0] up_cnt,
  output logic [CNT_W-1:0] dn_cnt,
  output logic [CNT_W-1:0] jump_cnt
);

  typedef enum logic [1:0] {UNSYNC, TRACK, LOCKED} state_t;

  localparam logic [3:0]       LOCK_V  = 4'(LOCK_N);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t     state, state_nxt;
  logic [3:0] run, run_nxt;
  logic       dir_nxt;
  logic       up_ev, dn_ev, hold_ev, jump_ev, fault_set;

  // 2, 5 and 6 form a three-element sub-ring; everything else steps by one mod 16.
  function automatic logic [3:0] succ_up(input logic [3:0] x);
    case (x)
      4'd5:    return 4'd6;
      4'd6:    return 4'd2;
      4'd2:    return 4'd5;
      default: return x + 4'd1;
    endcase
  endfunction

  function automatic logic [3:0] succ_dn(input logic [3:0] x);
    case (x)
      4'd6:    return 4'd5;
      4'd2:    return 4'd6;
      4'd5:    return 4'd2;
      default: return x - 4'd1;
    endcase
  endfunction

  always_comb begin
    state_nxt = state;
    run_nxt   = run;
    dir_nxt   = dir;
    up_ev     = 1'b0;
    dn_ev     = 1'b0;
    hold_ev   = 1'b0;
    jump_ev   = 1'b0;
    fault_set = 1'b0;
    if (sample_en) begin
      if (state == UNSYNC) begin
        state_nxt = TRACK;
        run_nxt   = 4'd0;
      end else if (q_in == prev_q) begin
        hold_ev = 1'b1;
      end else begin
        up_ev   = (q_in == succ_up(prev_q));
        dn_ev   = !up_ev && (q_in == succ_dn(prev_q));
        jump_ev = !up_ev && !dn_ev;
        if (jump_ev) begin
          run_nxt   = 4'd0;
          state_nxt = TRACK;
          fault_set = (state == LOCKED);
        end else if (run == 4'd0 || up_ev == dir) begin
          dir_nxt = up_ev;
          if (run < LOCK_V) run_nxt = run + 4'd1;
          if (run_nxt == LOCK_V) state_nxt = LOCKED;
        end else begin
          // Reversal restarts the run with this step as its first member.
          run_nxt   = 4'd1;
          dir_nxt   = up_ev;
          state_nxt = TRACK;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= UNSYNC;
      run      <= 4'd0;
      dir      <= 1'b1;
      prev_q   <= 4'd0;
      step_up  <= 1'b0;
      step_dn  <= 1'b0;
      hold_det <= 1'b0;
      jump     <= 1'b0;
    end else begin
      state    <= state_nxt;
      run      <= run_nxt;
      dir      <= dir_nxt;
      if (sample_en) prev_q <= q_in;
      step_up  <= up_ev;
      step_dn  <= dn_ev;
      hold_det <= hold_ev;
      jump     <= jump_ev;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      up_cnt   <= '0;
      dn_cnt   <= '0;
      jump_cnt <= '0;
      fault    <= 1'b0;
    end else if (clr) begin
      up_cnt   <= '0;
      dn_cnt   <= '0;
      jump_cnt <= '0;
      fault    <= 1'b0;
    end else begin
      if (up_ev && up_cnt != CNT_MAX)     up_cnt   <= up_cnt + CNT_W'(1);
      if (dn_ev && dn_cnt != CNT_MAX)     dn_cnt   <= dn_cnt + CNT_W'(1);
      if (jump_ev && jump_cnt != CNT_MAX) jump_cnt <= jump_cnt + CNT_W'(1);
      if (fault_set)                      fault    <= 1'b1;
    end
  end

  assign locked = (state == LOCKED);

endmodule

// File: tb/tb_count_seq_checker.sv
// Bench for count_seq_checker: two instances (LOCK_N=3/CNT_W=8 and LOCK_N=1/CNT_W=2) against a behavioural model.
module tb_count_seq_checker;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       clr = 1'b0;
  logic       sample_en = 1'b0;
  logic [3:0] q_in = 4'd0;

  logic       a_up, a_dn, a_hold, a_jump, a_dir, a_lock, a_fault;
  logic [3:0] a_prev;
  logic [7:0] a_upc, a_dnc, a_jc;
  logic       b_up, b_dn, b_hold, b_jump, b_dir, b_lock, b_fault;
  logic [3:0] b_prev;
  logic [1:0] b_upc, b_dnc, b_jc;

  int total = 0;
  int bad = 0;
  bit go = 1'b0;

  count_seq_checker #(.LOCK_N(3), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .clr(clr), .sample_en(sample_en), .q_in(q_in),
    .step_up(a_up), .step_dn(a_dn), .hold_det(a_hold), .jump(a_jump),
    .dir(a_dir), .locked(a_lock), .fault(a_fault), .prev_q(a_prev),
    .up_cnt(a_upc), .dn_cnt(a_dnc), .jump_cnt(a_jc));

  count_seq_checker #(.LOCK_N(1), .CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .clr(clr), .sample_en(sample_en), .q_in(q_in),
    .step_up(b_up), .step_dn(b_dn), .hold_det(b_hold), .jump(b_jump),
    .dir(b_dir), .locked(b_lock), .fault(b_fault), .prev_q(b_prev),
    .up_cnt(b_upc), .dn_cnt(b_dnc), .jump_cnt(b_jc));

  always #5 clk = ~clk;

  // Behavioural model, one slot per instance.
  int lockp[2] = '{3, 1};
  int maxc[2]  = '{255, 3};
  bit m_sync[2], m_dir[2], m_lock[2], m_fault[2];
  bit e_up[2], e_dn[2], e_hold[2], e_jump[2];
  int m_run[2], m_prev[2], m_upc[2], m_dnc[2], m_jc[2];

  function automatic int su(input int x);
    if (x == 5) return 6;
    if (x == 6) return 2;
    if (x == 2) return 5;
    return (x + 1) % 16;
  endfunction

  function automatic int sd(input int x);
    if (x == 6) return 5;
    if (x == 2) return 6;
    if (x == 5) return 2;
    return (x + 15) % 16;
  endfunction

  task automatic model_reset(input int k);
    m_sync[k] = 0; m_dir[k] = 1; m_lock[k] = 0; m_fault[k] = 0;
    e_up[k] = 0; e_dn[k] = 0; e_hold[k] = 0; e_jump[k] = 0;
    m_run[k] = 0; m_prev[k] = 0; m_upc[k] = 0; m_dnc[k] = 0; m_jc[k] = 0;
  endtask

  task automatic model_step(input int k);
    int q;
    bit d;
    q = int'(q_in);
    e_up[k] = 0; e_dn[k] = 0; e_hold[k] = 0; e_jump[k] = 0;
    if (sample_en) begin
      if (!m_sync[k]) begin
        m_sync[k] = 1;
        m_run[k] = 0;
      end else if (q == m_prev[k]) begin
        e_hold[k] = 1;
      end else if (q == su(m_prev[k]) || q == sd(m_prev[k])) begin
        d = (q == su(m_prev[k]));
        if (d) begin e_up[k] = 1; m_upc[k] = (m_upc[k] < maxc[k]) ? m_upc[k] + 1 : maxc[k]; end
        else   begin e_dn[k] = 1; m_dnc[k] = (m_dnc[k] < maxc[k]) ? m_dnc[k] + 1 : maxc[k]; end
        if (m_run[k] == 0 || d == m_dir[k]) begin
          m_run[k] = (m_run[k] + 1 > lockp[k]) ? lockp[k] : m_run[k] + 1;
          if (m_run[k] == lockp[k]) m_lock[k] = 1;
        end else begin
          m_run[k] = 1;
          m_lock[k] = 0;
        end
        m_dir[k] = d;
      end else begin
        e_jump[k] = 1;
        m_jc[k] = (m_jc[k] < maxc[k]) ? m_jc[k] + 1 : maxc[k];
        if (m_lock[k]) m_fault[k] = 1;
        m_lock[k] = 0;
        m_run[k] = 0;
      end
      m_prev[k] = q;
    end
    if (clr) begin
      m_upc[k] = 0; m_dnc[k] = 0; m_jc[k] = 0; m_fault[k] = 0;
    end
  endtask

  always @(posedge clk or posedge rst) begin
    for (int k = 0; k < 2; k++) begin
      if (rst) model_reset(k);
      else model_step(k);
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic cmp_inst(input int k, input logic u, input logic dn, input logic h,
                          input logic j, input logic d, input logic l, input logic f,
                          input logic [3:0] p, input logic [7:0] uc, input logic [7:0] dc,
                          input logic [7:0] jc);
    chk($sformatf("i%0d.step_up", k), 32'(u), int'(e_up[k]));
    chk($sformatf("i%0d.step_dn", k), 32'(dn), int'(e_dn[k]));
    chk($sformatf("i%0d.hold_det", k), 32'(h), int'(e_hold[k]));
    chk($sformatf("i%0d.jump", k), 32'(j), int'(e_jump[k]));
    chk($sformatf("i%0d.dir", k), 32'(d), int'(m_dir[k]));
    chk($sformatf("i%0d.locked", k), 32'(l), int'(m_lock[k]));
    chk($sformatf("i%0d.fault", k), 32'(f), int'(m_fault[k]));
    chk($sformatf("i%0d.prev_q", k), 32'(p), m_prev[k]);
    chk($sformatf("i%0d.up_cnt", k), 32'(uc), m_upc[k]);
    chk($sformatf("i%0d.dn_cnt", k), 32'(dc), m_dnc[k]);
    chk($sformatf("i%0d.jump_cnt", k), 32'(jc), m_jc[k]);
  endtask

  always @(negedge clk) begin
    if (go) begin
      cmp_inst(0, a_up, a_dn, a_hold, a_jump, a_dir, a_lock, a_fault, a_prev, a_upc, a_dnc, a_jc);
      cmp_inst(1, b_up, b_dn, b_hold, b_jump, b_dir, b_lock, b_fault, b_prev,
               8'(b_upc), 8'(b_dnc), 8'(b_jc));
    end
  end

  // Stimulus helpers: all start and end on a negedge.
  task automatic smp(input logic [3:0] v);
    sample_en = 1'b1;
    q_in = v;
    @(negedge clk);
    sample_en = 1'b0;
  endtask

  task automatic idle(input int n);
    sample_en = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic do_rst();
    sample_en = 1'b0;
    clr = 1'b0;
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("rst.locked", 32'(a_lock), 0);
    chk("rst.dir", 32'(a_dir), 1);
    chk("rst.prev_q", 32'(a_prev), 0);
    chk("rst.up_cnt", 32'(a_upc), 0);
    chk("rst.pulses", 32'({a_up, a_dn, a_hold, a_jump}), 0);
    @(negedge clk);
    @(posedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] lastq;
    bit rdir;
    int r;
    logic [3:0] v;

    repeat (3) @(negedge clk);
    chk("init.locked", 32'(a_lock), 0);
    chk("init.dir", 32'(a_dir), 1);
    chk("init.fault", 32'(a_fault), 0);
    chk("init.jump_cnt", 32'(a_jc), 0);
    go = 1'b1;
    @(posedge clk);
    #2 rst = 1'b0;
    @(negedge clk);

    // Up ring lock
    smp(4'd5); chk("up.first_nopulse", 32'(a_up), 0);
    smp(4'd6); chk("up.s2", 32'(a_up), 1); chk("up.s2_lock", 32'(a_lock), 0);
    smp(4'd2); chk("up.s3", 32'(a_up), 1); chk("up.s3_lock", 32'(a_lock), 0);
    smp(4'd5); chk("up.s4_lock", 32'(a_lock), 1);
    smp(4'd6); chk("up.s5", 32'(a_up), 1); chk("up.up_cnt", 32'(a_upc), 4);
    chk("up.jump", 32'(a_jump), 0);
    idle(1); chk("up.idle_nopulse", 32'(a_up), 0);
    do_rst();

    // Down with wrap, then holds
    smp(4'd1); smp(4'd0); smp(4'd15); smp(4'd14);
    chk("dn.step_dn", 32'(a_dn), 1); chk("dn.dir", 32'(a_dir), 0);
    chk("dn.locked", 32'(a_lock), 1); chk("dn.prev_q", 32'(a_prev), 14);
    chk("dn.dn_cnt", 32'(a_dnc), 3);
    smp(4'd14); chk("dn.hold", 32'(a_hold), 1); chk("dn.hold_lock", 32'(a_lock), 1);
    smp(4'd14); chk("dn.hold2", 32'(a_hold), 1); chk("dn.hold_cnt", 32'(a_dnc), 3);
    do_rst();

    // Fault on jump while locked
    smp(4'd7); smp(4'd8); smp(4'd9); smp(4'd10);
    chk("flt.locked", 32'(a_lock), 1);
    smp(4'd3);
    chk("flt.jump", 32'(a_jump), 1); chk("flt.fault", 32'(a_fault), 1);
    chk("flt.unlock", 32'(a_lock), 0); chk("flt.jump_cnt", 32'(a_jc), 1);
    smp(4'd4); chk("flt.step_up", 32'(a_up), 1); chk("flt.sticky", 32'(a_fault), 1);
    smp(4'd5); chk("flt.run2_lock", 32'(a_lock), 0);
    smp(4'd6); chk("flt.run3_lock", 32'(a_lock), 1);
    do_rst();

    // Reversal while locked, then clr together with a jump while locked
    smp(4'd0); smp(4'd1); smp(4'd2); smp(4'd5);
    chk("rev.locked", 32'(a_lock), 1);
    smp(4'd2);
    chk("rev.step_dn", 32'(a_dn), 1); chk("rev.unlock", 32'(a_lock), 0);
    chk("rev.dir", 32'(a_dir), 0); chk("rev.fault", 32'(a_fault), 0);
    smp(4'd6); smp(4'd5); chk("clr.relock", 32'(a_lock), 1);
    clr = 1'b1; smp(4'd9); clr = 1'b0;
    chk("clr.jump", 32'(a_jump), 1); chk("clr.fault", 32'(a_fault), 0);
    chk("clr.up_cnt", 32'(a_upc), 0); chk("clr.dn_cnt", 32'(a_dnc), 0);
    chk("clr.jump_cnt", 32'(a_jc), 0); chk("clr.prev_q", 32'(a_prev), 9);
    smp(4'd8); chk("clr.track_dn", 32'(a_dn), 1); chk("clr.track_unlock", 32'(a_lock), 0);

    // Reset mid-stream with idle gaps
    smp(4'd3); smp(4'd4); idle(2);
    do_rst();
    idle(1);
    smp(4'd7); chk("rs.first_nopulse", 32'({a_up, a_dn, a_hold, a_jump}), 0);
    smp(4'd8); chk("rs.step_up", 32'(a_up), 1);
    do_rst();

    // Counter saturation on the narrow instance
    smp(4'd0); smp(4'd1); smp(4'd2); smp(4'd5); smp(4'd6); smp(4'd2);
    chk("sat.wide", 32'(a_upc), 5);
    chk("sat.narrow", 32'(b_upc), 3);
    chk("sat.narrow_lock", 32'(b_lock), 1);

    // Randomized run against the model
    lastq = 4'd2;
    rdir = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 199) == 0) do_rst();
      if ($urandom_range(0, 9) == 0) rdir = !rdir;
      r = int'($urandom_range(0, 9));
      if (r < 6)       v = 4'((rdir ? su(int'(lastq)) : sd(int'(lastq))));
      else if (r == 6) v = lastq;
      else if (r < 9)  v = 4'((rdir ? sd(int'(lastq)) : su(int'(lastq))));
      else             v = 4'($urandom_range(0, 15));
      sample_en = ($urandom_range(0, 9) < 7);
      clr = ($urandom_range(0, 29) == 0);
      q_in = v;
      if (sample_en) lastq = v;
      @(negedge clk);
    end
    sample_en = 1'b0;
    clr = 1'b0;
    idle(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/count_seq_checker.md
# count_seq_checker

Sample-side companion to the 4-bit up/down ring counter: observes the counter's `q` stream and decodes each sampled transition as an up step, down step, hold or jump. It uses the same successor rules as the counter. It tracks direction lock, flags faults, and keeps saturating event statistics. It sits on the counter's output bus in FINAL_REVIEW test systems and in self-checking benches.

## Interface
- `LOCK_N`, default 3: consecutive same-direction steps required to assert `locked` (legal range 1..15).
- `CNT_W`, default 8: width of the statistic counters.

- `clk`  in  1  clock
- `rst`  in  1  reset, asynchronous, active-high
- `clr`  in  1  synchronous clear of the statistics and the sticky `fault` flag
- `sample_en`  in  1  qualifies `q_in` this cycle
- `q_in`  in  4  counter value under observation
- `step_up`  out  1  pulse: last sample was the up-successor of the previous sample
- `step_dn`  out  1  pulse: last sample was the down-successor
- `hold_det`  out  1  pulse: last sample equalled the previous sample
- `jump`  out  1  pulse: last sample was none of the above
- `dir`  out  1  direction of the most recent step (1 = up)
- `locked`  out  1  FSM in LOCKED
- `fault`  out  1  sticky: a jump occurred while LOCKED
- `prev_q`  out  4  last accepted sample
- `up_cnt`, `dn_cnt`, `jump_cnt`  out  `CNT_W`  saturating event counts

## Operation
- Up-successor `su(x)`: 5→6, 6→2, 2→5; otherwise x+1 mod 16 (15→0).
- Down-successor `sd(x)`: 6→5, 2→6, 5→2; otherwise x−1 mod 16 (0→15).
- `su(x)` ≠ `sd(x)` for all x, so classification is unambiguous. Priority order: hold, up, down, jump.
- FSM states:
  - UNSYNC: no valid previous sample.
  - TRACK: has a previous sample, not locked.
  - LOCKED: run has reached `LOCK_N`.
- Run counter `run` saturates at `LOCK_N`.
- Transitions are evaluated only when `sample_en`=1. Every accepted sample loads `prev_q`.
  - UNSYNC: no classification and no pulses. Go to TRACK with `run`=0.
  - TRACK, step in the same direction as `dir` (or `run`=0): `run`+1, `dir` updated. When `run` reaches `LOCK_N`, go to LOCKED.
  - TRACK, step in the opposite direction: `run`=1, `dir` flips.
  - TRACK, jump: `run`=0, stay in TRACK.
  - Hold in any synced state: no change to `run`, `dir` or state.
  - LOCKED, same-direction step: stay in LOCKED.
  - LOCKED, reversal: go to TRACK with `run`=1 and `dir` flipped. No fault.
  - LOCKED, jump: go to TRACK with `run`=0 and set `fault`.
- Statistics: `up_cnt`, `dn_cnt` and `jump_cnt` each increment on their event and stick at 2^CNT_W−1. Holds are not counted.
- `clr`:
  - Zeroes the three counters and `fault`. `clr` wins over an increment or a fault set in the same cycle.
  - Does not affect the FSM, `run`, `dir` or `prev_q`. A sample in the same cycle still advances them.
- Reset mid-stream: all state returns to reset values immediately. The next sample is treated as the first (UNSYNC).

## Timing
- Classification pulses are registered, high for exactly the one cycle after the accepting `sample_en` edge. With `sample_en`=0 all pulses are 0.
- `dir`, `locked`, `prev_q` and the counters update on the same edge as the pulses.
- Back-to-back `sample_en` is supported at full rate. Each sample is compared against the sample immediately before it.
- Reset values:
  - All pulses 0.
  - `dir`=1, `locked`=0, `fault`=0, `prev_q`=0.
  - All counters 0, FSM in UNSYNC, `run`=0.
- Lock latency: `locked` rises on the edge that accepts the `LOCK_N`-th consecutive same-direction step, which is sample `LOCK_N`+1 after sync.

## Test plan
- Up ring with `LOCK_N`=3: samples 5, 6, 2, 5, 6 → `step_up` on samples 2–5; `locked`=1 after sample 4; `up_cnt`=4; `jump`=0 throughout.
- Down with wrap: samples 1, 0, 15, 14 → `step_dn`×3; `dir`=0; `locked`=1; `prev_q`=14. Then 14, 14 → `hold_det`, with `locked` still 1 and counters unchanged.
- Fault: lock up on 7, 8, 9, 10, then sample 3 → `jump` pulse, `fault`=1, `locked`=0, `jump_cnt`=1. Then 4 → `step_up` with `run`=1 and `fault` still 1.
- Reversal: lock up on 0, 1, 2, 5, then sample 2 → `step_dn`, `locked`=0, `dir`=0, `fault`=0.
- `clr` together with a jump while locked → counters 0 and `fault`=0 after the edge; `jump` pulse still seen; FSM in TRACK.
- `rst` asserted mid-stream with `sample_en` idle for gaps → all outputs return to reset values asynchronously. The first sample after reset produces no pulse. With `CNT_W`=2, five up steps leave `up_cnt`=3.
